// File: rtl/lsu_param_if.sv
// -----------------------------------------------------------------------------
// lsu_param_if
// Memory-side handshake bundle between a load/store unit and the data-memory
// arbiter. Read and write channels each use a valid/ready pair.
//   master : load/store unit side (drives requests, receives ready/read data)
//   slave  : memory arbiter side (receives requests, drives ready/read data)
// -----------------------------------------------------------------------------
interface lsu_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              mem_read_valid;
  logic [ADDR_W-1:0] mem_read_address;
  logic              mem_read_ready;
  logic [DATA_W-1:0] mem_read_data;
  logic              mem_write_valid;
  logic [ADDR_W-1:0] mem_write_address;
  logic [DATA_W-1:0] mem_write_data;
  logic              mem_write_ready;

  modport master (
    output mem_read_valid, mem_read_address,
    input  mem_read_ready, mem_read_data,
    output mem_write_valid, mem_write_address, mem_write_data,
    input  mem_write_ready
  );

  modport slave (
    input  mem_read_valid, mem_read_address,
    output mem_read_ready, mem_read_data,
    input  mem_write_valid, mem_write_address, mem_write_data,
    output mem_write_ready
  );
endinterface

// File: rtl/lsu_param.sv
// -----------------------------------------------------------------------------
// lsu_param
// Per-thread load/store unit. Issues one memory read (LDR) or write (STR) per
// instruction, launched when the core pipeline reaches REQUEST_STATE and
// retired at UPDATE_STATE. Address = rs + imm (modulo 2^ADDR_W).
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   enable                     thread active; low freezes every register
//   core_state                 core pipeline state
//   decoded_mem_read_enable    LDR decoded
//   decoded_mem_write_enable   STR decoded
//   rs, rt, imm                base address, store data, address offset
//   mem (lsu_param_if.master)  read/write valid/ready memory channels
//   lsu_state                  IDLE=00 REQUESTING=01 WAITING=10 DONE=11
//   lsu_out                    last load result
//   lsu_err                    current operation ended in error
//
// Build option: define LSU_TIMEOUT_EN to abort a request that has waited
// TIMEOUT_CYCLES enabled cycles without a ready (ends in DONE with lsu_err=1).
// -----------------------------------------------------------------------------
module lsu_param #(
  parameter int                 DATA_W         = 8,
  parameter int                 ADDR_W         = 8,
  parameter int                 STATE_W        = 3,
  parameter logic [STATE_W-1:0] REQUEST_STATE  = 3'b011,
  parameter logic [STATE_W-1:0] UPDATE_STATE   = 3'b110,
  parameter int                 TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [STATE_W-1:0] core_state,
  input  logic               decoded_mem_read_enable,
  input  logic               decoded_mem_write_enable,
  input  logic [DATA_W-1:0]  rs,
  input  logic [DATA_W-1:0]  rt,
  input  logic [ADDR_W-1:0]  imm,
  lsu_param_if.master        mem,
  output logic [1:0]         lsu_state,
  output logic [DATA_W-1:0]  lsu_out,
  output logic               lsu_err
);

  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    REQUESTING = 2'b01,
    WAITING    = 2'b10,
    DONE       = 2'b11
  } state_t;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("lsu_param: TIMEOUT_CYCLES must be at least 1");
  end

  // Base address: truncate or zero-extend rs to the address width.
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] eff_addr;

  if (DATA_W >= ADDR_W) begin : g_base_trunc
    assign base_addr = rs[ADDR_W-1:0];
  end else begin : g_base_zext
    assign base_addr = {{(ADDR_W-DATA_W){1'b0}}, rs};
  end

  // Wrap-around is intentional: the sum is kept to ADDR_W bits.
  assign eff_addr = base_addr + imm;

  state_t            state_q, state_d;
  logic              is_write_q, is_write_d;  // op type latched at launch
  logic              rd_valid_q, rd_valid_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              wr_valid_q, wr_valid_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              err_q, err_d;

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d    = state_q;
    is_write_d = is_write_q;
    rd_valid_d = rd_valid_q;
    rd_addr_d  = rd_addr_q;
    wr_valid_d = wr_valid_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    out_d      = out_q;
    err_d      = err_q;
`ifdef LSU_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif

    if (enable) begin
      case (state_q)
        IDLE: begin
          if (core_state == REQUEST_STATE) begin
            if (decoded_mem_read_enable && decoded_mem_write_enable) begin
              // Conflicting decode: retire with an error, never touch memory.
              state_d = DONE;
              err_d   = 1'b1;
            end else if (decoded_mem_read_enable || decoded_mem_write_enable) begin
              state_d    = REQUESTING;
              is_write_d = decoded_mem_write_enable;
            end
          end
        end

        REQUESTING: begin
          if (is_write_q) begin
            wr_valid_d = 1'b1;
            wr_addr_d  = eff_addr;
            wr_data_d  = rt;
          end else begin
            rd_valid_d = 1'b1;
            rd_addr_d  = eff_addr;
          end
          state_d = WAITING;
`ifdef LSU_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end

        WAITING: begin
          // Only the channel of the latched op is watched; ready counts only
          // while our own valid is up.
          if (!is_write_q && rd_valid_q && mem.mem_read_ready) begin
            rd_valid_d = 1'b0;
            out_d      = mem.mem_read_data;
            state_d    = DONE;
          end else if (is_write_q && wr_valid_q && mem.mem_write_ready) begin
            wr_valid_d = 1'b0;
            state_d    = DONE;
          end
`ifdef LSU_TIMEOUT_EN
          // This is the TIMEOUT_CYCLES-th waiting cycle with no ready.
          else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            rd_valid_d = 1'b0;
            wr_valid_d = 1'b0;
            err_d      = 1'b1;
            state_d    = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
`endif
        end

        DONE: begin
          if (core_state == UPDATE_STATE) begin
            state_d = IDLE;
            err_d   = 1'b0;
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      is_write_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_addr_q  <= '0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      out_q      <= '0;
      err_q      <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      is_write_q <= is_write_d;
      rd_valid_q <= rd_valid_d;
      rd_addr_q  <= rd_addr_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      out_q      <= out_d;
      err_q      <= err_d;
`ifdef LSU_TIMEOUT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign mem.mem_read_valid    = rd_valid_q;
  assign mem.mem_read_address  = rd_addr_q;
  assign mem.mem_write_valid   = wr_valid_q;
  assign mem.mem_write_address = wr_addr_q;
  assign mem.mem_write_data    = wr_data_q;
  assign lsu_state             = state_q;
  assign lsu_out               = out_q;
  assign lsu_err               = err_q;

endmodule

// File: tb/tb_lsu_param.sv
// -----------------------------------------------------------------------------
// tb_lsu_param
// Self-checking bench for lsu_param (8-bit data/address, TIMEOUT_CYCLES=4).
// Expected addresses, data and results come from a simple transaction-level
// model: address = (rs + imm) mod 256, lsu_out = data of the last completed
// load, valid held until the cycle in which ready is presented.
// Timeout scenarios run only when LSU_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_lsu_param;
  localparam int         DW  = 8;
  localparam int         AW  = 8;
  localparam logic [2:0] REQ = 3'b011;
  localparam logic [2:0] UPD = 3'b110;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [2:0]    core_state;
  logic          decoded_mem_read_enable;
  logic          decoded_mem_write_enable;
  logic [DW-1:0] rs, rt;
  logic [AW-1:0] imm;
  logic [1:0]    lsu_state;
  logic [DW-1:0] lsu_out;
  logic          lsu_err;

  lsu_param_if #(.DATA_W(DW), .ADDR_W(AW)) mem_if ();

  lsu_param #(
    .DATA_W(DW), .ADDR_W(AW), .STATE_W(3),
    .REQUEST_STATE(REQ), .UPDATE_STATE(UPD), .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .core_state(core_state),
    .decoded_mem_read_enable(decoded_mem_read_enable),
    .decoded_mem_write_enable(decoded_mem_write_enable),
    .rs(rs), .rt(rt), .imm(imm), .mem(mem_if),
    .lsu_state(lsu_state), .lsu_out(lsu_out), .lsu_err(lsu_err)
  );

  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [7:0]  exp_out  = 8'h00;   // model: result of last completed load

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full instruction: launch, wait dly cycles after valid, answer, retire.
  task automatic do_op(input bit rd, input bit wr, input logic [7:0] b,
                       input logic [7:0] t, input logic [7:0] o,
                       input int dly, input logic [7:0] rdata);
    logic [7:0] ea;
    ea = b + o;                      // 8-bit arithmetic wraps naturally
    decoded_mem_read_enable  = rd;
    decoded_mem_write_enable = wr;
    rs = b; rt = t; imm = o;
    core_state = REQ;
    tick();
    core_state = 3'b000;
    if (rd && wr) begin
      check("conflict_state", lsu_state, 2'b11);
      check("conflict_err", lsu_err, 1'b1);
      check("conflict_rvalid", mem_if.mem_read_valid, 1'b0);
      check("conflict_wvalid", mem_if.mem_write_valid, 1'b0);
    end else begin
      check("req_state", lsu_state, 2'b01);
      check("req_novalid", {mem_if.mem_read_valid, mem_if.mem_write_valid}, 2'b00);
      tick();
      // Flip decode enables: the in-flight op must not change.
      decoded_mem_read_enable  = ~rd;
      decoded_mem_write_enable = ~rd;
      check("wait_state", lsu_state, 2'b10);
      check("rvalid", mem_if.mem_read_valid, rd);
      check("wvalid", mem_if.mem_write_valid, wr);
      if (rd) check("raddr", mem_if.mem_read_address, ea);
      else begin
        check("waddr", mem_if.mem_write_address, ea);
        check("wdata", mem_if.mem_write_data, t);
      end
      for (int k = 0; k < dly; k++) begin
        // The other channel's ready must be ignored.
        if (rd) mem_if.mem_write_ready = 1'($urandom_range(0, 1));
        else    mem_if.mem_read_ready  = 1'($urandom_range(0, 1));
        tick();
        check("hold_state", lsu_state, 2'b10);
        check("hold_valid", rd ? mem_if.mem_read_valid : mem_if.mem_write_valid, 1'b1);
        check("hold_addr", rd ? mem_if.mem_read_address : mem_if.mem_write_address, ea);
      end
      mem_if.mem_read_ready  = rd;
      mem_if.mem_write_ready = wr;
      mem_if.mem_read_data   = rdata;
      tick();
      mem_if.mem_read_ready  = 1'b0;
      mem_if.mem_write_ready = 1'b0;
      if (rd) exp_out = rdata;
      check("done_state", lsu_state, 2'b11);
      check("done_valids", {mem_if.mem_read_valid, mem_if.mem_write_valid}, 2'b00);
      check("done_err", lsu_err, 1'b0);
      check("done_out", lsu_out, exp_out);
    end
    core_state = UPD;
    tick();
    core_state = 3'b000;
    check("retire_state", lsu_state, 2'b00);
    check("retire_err", lsu_err, 1'b0);
    check("retire_out", lsu_out, exp_out);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; core_state = 3'b000;
    decoded_mem_read_enable = 1'b0; decoded_mem_write_enable = 1'b0;
    rs = '0; rt = '0; imm = '0;
    mem_if.mem_read_ready = 1'b0; mem_if.mem_write_ready = 1'b0;
    mem_if.mem_read_data = '0;
    repeat (3) tick();
    reset = 1'b0;
    check("rst_state", lsu_state, 2'b00);
    check("rst_out", lsu_out, 8'h00);
    check("rst_err", lsu_err, 1'b0);
    check("rst_valids", {mem_if.mem_read_valid, mem_if.mem_write_valid}, 2'b00);
    check("rst_addr", {mem_if.mem_read_address, mem_if.mem_write_address}, 16'h0000);
    check("rst_wdata", mem_if.mem_write_data, 8'h00);

    // Idle with no decode: stays IDLE.
    core_state = REQ;
    tick();
    core_state = 3'b000;
    check("idle_stay", lsu_state, 2'b00);

    // Directed: load, store, wrap, conflict.
    do_op(1'b1, 1'b0, 8'h10, 8'h00, 8'h04, 2, 8'hA5);
    do_op(1'b0, 1'b1, 8'h20, 8'h5A, 8'h00, 0, 8'h00);
    do_op(1'b1, 1'b0, 8'hFF, 8'h00, 8'h02, 1, 8'h3C);
    do_op(1'b1, 1'b1, 8'h44, 8'h11, 8'h01, 0, 8'h00);

    // Randomized transactions (ready delay kept below the timeout).
    for (int i = 0; i < 24; i++) begin
      int sel;
      sel = $urandom_range(0, 5);
      do_op(sel != 1, sel == 1 || sel == 5,
            8'($urandom), 8'($urandom), 8'($urandom),
            $urandom_range(0, 3), 8'($urandom));
    end

    // Freeze in WAITING, then reset mid-operation.
    decoded_mem_read_enable = 1'b1; decoded_mem_write_enable = 1'b0;
    rs = 8'h30; imm = 8'h01; core_state = REQ;
    tick();
    core_state = 3'b000;
    tick();
    check("frz_enter", lsu_state, 2'b10);
    enable = 1'b0;
    mem_if.mem_read_ready = 1'b1;
    mem_if.mem_read_data  = 8'h77;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("frz_state", lsu_state, 2'b10);
      check("frz_valid", mem_if.mem_read_valid, 1'b1);
      check("frz_addr", mem_if.mem_read_address, 8'h31);
      check("frz_out", lsu_out, exp_out);
    end
    mem_if.mem_read_ready = 1'b0;
    enable = 1'b1;
    tick();
    check("unfrz_state", lsu_state, 2'b10);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_out = 8'h00;
    check("midrst_valid", mem_if.mem_read_valid, 1'b0);
    check("midrst_state", lsu_state, 2'b00);
    check("midrst_out", lsu_out, 8'h00);

    // Unit works normally after the reset.
    do_op(1'b1, 1'b0, 8'h08, 8'h00, 8'h08, 0, 8'hC3);

`ifdef LSU_TIMEOUT_EN
    // No ready: abort after the 4th waiting cycle.
    decoded_mem_read_enable = 1'b1; decoded_mem_write_enable = 1'b0;
    rs = 8'h50; imm = 8'h00; core_state = REQ;
    tick();
    core_state = 3'b000;
    tick();
    check("to_wait", lsu_state, 2'b10);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("to_still_wait", lsu_state, 2'b10);
      check("to_still_valid", mem_if.mem_read_valid, 1'b1);
    end
    tick();
    check("to_state", lsu_state, 2'b11);
    check("to_err", lsu_err, 1'b1);
    check("to_valid", mem_if.mem_read_valid, 1'b0);
    check("to_out", lsu_out, exp_out);
    core_state = UPD;
    tick();
    core_state = 3'b000;
    check("to_retire_err", lsu_err, 1'b0);
    check("to_retire_state", lsu_state, 2'b00);
    // Ready on the expiry cycle wins (read and write).
    do_op(1'b1, 1'b0, 8'h60, 8'h00, 8'h02, 3, 8'h9E);
    do_op(1'b0, 1'b1, 8'h61, 8'hE7, 8'h02, 3, 8'h00);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/lsu_param.md
Name: lsu_param

Overview:
- Parametrised per-thread load/store unit. Sits between one thread's register file/decoder and the data-memory arbiter of a compute core.
- Issues one read (LDR) or one write (STR) per instruction, gated by the core pipeline state, using a valid/ready handshake.
- Generalises the core's fixed 8-bit LSU: configurable data/address widths, base+offset addressing, command-conflict detection and an optional request timeout.

Parameters:
- DATA_W, 8: data width of registers and memory data.
- ADDR_W, 8: memory address width.
- STATE_W, 3: width of core_state.
- REQUEST_STATE, 3'b011: core_state value that launches a memory operation.
- UPDATE_STATE, 3'b110: core_state value that retires a completed operation.
- TIMEOUT_CYCLES, 64: WAITING cycles before abort; used only with LSU_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  thread active. Low = all state and outputs frozen.
- core_state  in  STATE_W  core pipeline state.
- decoded_mem_read_enable  in  1  LDR decoded.
- decoded_mem_write_enable  in  1  STR decoded.
- rs  in  DATA_W  base address register.
- rt  in  DATA_W  store data register.
- imm  in  ADDR_W  address offset; 0 for plain LDR/STR.
- mem_read_valid  out  1  read request.
- mem_read_address  out  ADDR_W  read address.
- mem_read_ready  in  1  read data returned.
- mem_read_data  in  DATA_W  read data.
- mem_write_valid  out  1  write request.
- mem_write_address  out  ADDR_W  write address.
- mem_write_data  out  DATA_W  write data.
- mem_write_ready  in  1  write accepted.
- lsu_state  out  2  IDLE=00, REQUESTING=01, WAITING=10, DONE=11.
- lsu_out  out  DATA_W  last load result.
- lsu_err  out  1  current operation ended in error.

Behaviour:
- Reset: lsu_state=IDLE, lsu_out=0, lsu_err=0, both valids=0, all addresses/data=0. Reset mid-operation drops any valid at that same edge. No pending request survives reset.
- All transitions below require enable=1. With enable=0 every register holds, including asserted valids.
- Address = rs[ADDR_W-1:0] + imm, modulo 2^ADDR_W. Wrap-around is silent (0xFF+0x02 -> 0x01 at ADDR_W=8).
- Op latch: on IDLE->REQUESTING the unit captures the operation type (read or write). Later changes to the decode enables do not alter an in-flight operation.
- IDLE:
  - core_state==REQUEST_STATE with exactly one enable set -> REQUESTING.
  - Both enables set -> DONE with lsu_err=1, no memory request.
  - Neither enable set -> stay IDLE.
- REQUESTING (exactly 1 cycle):
  - Read: mem_read_valid<=1, mem_read_address<=addr.
  - Write: mem_write_valid<=1, mem_write_address<=addr, mem_write_data<=rt[DATA_W-1:0].
  - -> WAITING.
- WAITING:
  - Valid, address and data are held stable until the matching ready is sampled high while valid=1.
  - On that edge: valid<=0; a read also does lsu_out<=mem_read_data; -> DONE.
  - A ready seen before valid is asserted is ignored. The ready of the other channel is ignored.
- DONE: hold lsu_out. core_state==UPDATE_STATE -> IDLE and lsu_err<=0.
- Minimum latency REQUEST to DONE: 3 edges with ready already high in WAITING (IDLE->REQ, REQ->WAIT, WAIT->DONE).
- A read never asserts write-side outputs and vice versa. Only one valid is ever high at a time.

Optional Feature:
- Macro LSU_TIMEOUT_EN.
- Defined:
  - A counter clears on entering WAITING and increments each enabled WAITING cycle.
  - When it reaches TIMEOUT_CYCLES with no ready: drop valid, set lsu_err=1, leave lsu_out unchanged, -> DONE.
  - If ready arrives on the same cycle as expiry, ready wins (normal completion, lsu_err=0).
- Not defined: no counter, WAITING waits indefinitely, lsu_err is set only by command conflict.

Test Plan:
- Load: rs=0x10, imm=0x04, read enable, core_state=011, ready high 2 cycles after valid with data 0xA5 -> mem_read_address=0x14, valid high 3 cycles, lsu_out=0xA5, state DONE; core_state=110 -> IDLE.
- Store: rs=0x20, rt=0x5A, imm=0, write enable, ready immediate -> mem_write_address=0x20, data=0x5A, valid for exactly 1 cycle, mem_read_valid stays 0, lsu_out unchanged.
- Wrap/conflict: rs=0xFF, imm=0x02 -> address 0x01. Both enables set in REQUEST -> DONE, lsu_err=1, no valid ever asserted; UPDATE clears lsu_err.
- Freeze/reset: enable=0 during WAITING for 5 cycles -> valid and state held, ready ignored. Reset asserted mid-WAITING -> next edge valid=0, state IDLE, lsu_out=0.
- LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4, ready never asserted -> after 4 WAITING cycles valid=0, lsu_err=1, DONE. Repeat with ready on the 4th cycle -> normal completion, lsu_err=0.
